fifo2mm_mo: RTL and testbench
=============================

Name: fifo2mm_mo

Overview:
- Next-generation FIFO-to-memory AXI4 write master for the s2mm path.
- Drains a first-word-fall-through FIFO of frame data into memory as fixed-length INCR bursts.
- Keeps up to C_MAX_OUTSTANDING bursts in flight.
- Frame length (in bursts) is programmable at run time; frame start and completion are signalled to the frame-buffer controller.

Parameters:
- C_M_AXI_BURST_LEN, 16, beats per burst (1,2,4,...,256).
- C_M_AXI_ID_WIDTH, 1, AXI ID width; AWID driven 0.
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 64, data width (32..512).
- C_MAX_OUTSTANDING, 4, maximum AW accepted minus B received (1..16).
- C_FRAME_BURSTS_WIDTH, 16, width of frame_bursts.

Ports:
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESETN  in  1  synchronous active-low reset.
- sof  in  1  start-of-frame flag accompanying din.
- din  in  DATA_WIDTH  FIFO head word.
- empty  in  1  FIFO empty.
- rd_en  out  1  FIFO pop.
- base_addr  in  ADDR_WIDTH  frame base; sampled on frame_pulse.
- frame_bursts  in  C_FRAME_BURSTS_WIDTH  bursts per frame; sampled on frame_pulse.
- frame_pulse  out  1  frame accepted.
- frame_done  out  1  last B response of frame received.
- resp_err  out  1  sticky SLVERR/DECERR flag.
- M_AXI_AW* / M_AXI_W* / M_AXI_B*  standard AXI4 write channels, same set and widths as the existing s2mm master.

Behaviour:
- Reset (synchronous, M_AXI_ARESETN=0):
  - All of the following are 0: rd_en, frame_pulse, frame_done, resp_err, AWVALID, WVALID, WLAST.
  - AWADDR is 0, all counters are 0, and the FSM is in IDLE.
  - Reset mid-burst abandons in-flight transactions; the system is reset together.
- Constants:
  - AWLEN = BURST_LEN-1.
  - AWSIZE = log2(DATA_WIDTH/8).
  - AWBURST = INCR, AWCACHE = 4'b0010, AWLOCK/AWPROT/AWQOS = 0.
  - WSTRB = all ones.
  - BREADY = 1 at all times.
- Input stage:
  - One-word holding register with r_dvalid.
  - rd_en = ~empty & (~r_dvalid | pop), where pop = wnext in FRAME and pop = drop in IDLE.
  - Full throughput: one beat per cycle when the FIFO is non-empty and WREADY=1.
- FSM IDLE:
  - r_dvalid & ~sof: the word is discarded (drop=1), one word per cycle.
  - r_dvalid & sof: frame_pulse=1 for exactly one cycle (combinational in that cycle).
    - Next edge latches base_addr into the AW address register and latches frame_bursts (0 is clamped to 1).
    - Next edge clears aw_cnt, w_cnt, b_cnt and resp_err, and enters FRAME.
    - The sof word is retained as beat 0.
- FSM FRAME, AW channel:
  - AWVALID rises when aw_cnt < frame_bursts and outstanding < C_MAX_OUTSTANDING.
  - AWVALID is held, with stable AWADDR, until AWREADY.
  - On handshake: aw_cnt++, outstanding++, AWADDR += BURST_LEN*DATA_WIDTH/8.
  - AWVALID may re-assert the cycle after a handshake (back-to-back AW).
- FSM FRAME, W channel:
  - WVALID = r_dvalid & (w_pending > 0), where w_pending = AW handshakes minus completed W bursts. W never leads its AW.
  - A beat counter runs from 0 to BURST_LEN-1; WLAST is asserted on beat BURST_LEN-1 (always for BURST_LEN=1).
  - wnext & WLAST increments w_cnt.
  - sof on a mid-frame word is ignored and treated as data.
- FSM FRAME, B channel:
  - BVALID: b_cnt++, outstanding--.
  - AW handshake and BVALID in the same cycle leave outstanding unchanged.
  - When b_cnt reaches frame_bursts: frame_done=1 for one cycle, registered, then return to IDLE.
  - A sof word may already be held; it is processed in IDLE on the next cycle.
- Widths:
  - outstanding is clog2(C_MAX_OUTSTANDING+1) bits.
  - Burst counters are C_FRAME_BURSTS_WIDTH bits.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Alignment and boundary rules:
  - base_addr must be burst-size aligned; the block does not check this at run time.
  - Elaboration error if BURST_LEN*DATA_WIDTH/8 > 4096, so no burst crosses a 4K boundary.

Optional Feature:
- S2MM_RESP_ERR_EN defined:
  - resp_err is set on BVALID & BRESP[1], sticky until the next frame_pulse.
  - A 16-bit saturating error count is kept internally, visible for debug.
- Not defined: resp_err is tied 0 and there is no error logic.

Decomposition:
- Shared package fifo2mm_pkg holds:
  - FSM state typedef (IDLE, FRAME).
  - AXI constants (INCR, AWCACHE value).
  - clog2 function.
  - Burst-bytes localparam function.
- One natural sub-module: fifo2mm_wbeat, covering the holding register, beat counter, WLAST and w_pending tracking.

Test Plan:
1. Reset, then sof word with frame_bursts=4, BURST_LEN=16, all READY=1: frame_pulse once; AWADDR = base, base+0x80, base+0x100, base+0x180 (64-bit data); 64 W beats, WLAST on every 16th; frame_done one cycle after the 4th BVALID.
2. BVALID withheld, C_MAX_OUTSTANDING=2, frame_bursts=5: exactly 2 AW handshakes, then AWVALID stays 0 until the first BVALID.
3. Three non-sof words then a sof word in IDLE: three words dropped, no AXI activity, frame_pulse on the sof word, AWADDR = base_addr.
4. Random WREADY/AWREADY stalls with FIFO empty gaps: WDATA sequence matches FIFO order exactly, no W burst before its AW, WVALID never drops without wnext.
5. BRESP=2'b10 on burst 2 of 3 with S2MM_RESP_ERR_EN: resp_err rises the cycle after, stays 1 through frame_done, clears on next frame_pulse; without the macro it stays 0.
6. Reset asserted mid-burst (beat 7 of 16): the next cycle AWVALID, WVALID, frame_done and rd_en are 0; a following sof frame completes normally.

Source files
------------

// File: rtl/fifo2mm_pkg.sv
// fifo2mm_pkg: shared FSM state type, AXI attribute constants and elaboration helpers
// for the fifo2mm s2mm write master.
package fifo2mm_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [3:0] AXI_AWCACHE_VAL = 4'b0010;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int burst_bytes(input int burst_len, input int data_width);
        return burst_len * data_width / 8;
    endfunction

endpackage

// File: rtl/fifo2mm_wbeat.sv
// fifo2mm_wbeat: one-word FWFT holding register, W beat counter, WLAST generation and
// tracking of AW-accepted bursts whose W data is still owed.
module fifo2mm_wbeat
    import fifo2mm_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = 16,
    parameter int PEND_W    = 3
) (
    input  logic              clk,
    input  logic              srst_n_i,
    input  logic              empty_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              sof_i,
    input  logic              frame_active_i,
    input  logic              drop_i,
    input  logic              frame_start_i,
    input  logic              aw_hs_i,
    input  logic              wready_i,
    output logic              rd_en_o,
    output logic              dvalid_o,
    output logic              sof_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              wvalid_o,
    output logic              wlast_o,
    output logic              wnext_o
);

    localparam int BEAT_W = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic              dvalid_q, dvalid_d;
    logic              sof_q, sof_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              pop;
    logic              burst_end;

    assign wvalid_o  = frame_active_i & dvalid_q & (pend_q != '0);
    assign wnext_o   = wvalid_o & wready_i;
    assign wlast_o   = wvalid_o & (beat_q == LAST_BEAT);
    assign burst_end = wnext_o & wlast_o;
    assign pop       = frame_active_i ? wnext_o : drop_i;
    // Gated by reset so no FIFO word is popped and lost while the system is held in reset.
    assign rd_en_o   = srst_n_i & ~empty_i & (~dvalid_q | pop);
    assign dvalid_o  = dvalid_q;
    assign sof_o     = sof_q;
    assign wdata_o   = data_q;

    always_comb begin
        dvalid_d = dvalid_q;
        sof_d    = sof_q;
        data_d   = data_q;
        beat_d   = beat_q;
        pend_d   = pend_q;
        if (rd_en_o) begin
            dvalid_d = 1'b1;
            sof_d    = sof_i;
            data_d   = din_i;
        end else if (pop) begin
            dvalid_d = 1'b0;
        end
        if (frame_start_i) begin
            beat_d = '0;
            pend_d = '0;
        end else begin
            if (wnext_o) begin
                beat_d = wlast_o ? '0 : beat_q + 1'b1;
            end
            if (aw_hs_i && !burst_end) begin
                pend_d = pend_q + 1'b1;
            end else if (!aw_hs_i && burst_end) begin
                pend_d = pend_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srst_n_i) begin
            dvalid_q <= 1'b0;
            sof_q    <= 1'b0;
            data_q   <= '0;
            beat_q   <= '0;
            pend_q   <= '0;
        end else begin
            dvalid_q <= dvalid_d;
            sof_q    <= sof_d;
            data_q   <= data_d;
            beat_q   <= beat_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: rtl/fifo2mm_mo.sv
// fifo2mm_mo: drains a FWFT FIFO into memory as fixed-length AXI4 INCR bursts, multiple in flight.
// Optional S2MM_RESP_ERR_EN adds a sticky BRESP error flag and a saturating error count.
module fifo2mm_mo
    import fifo2mm_pkg::*;
#(
    parameter int C_M_AXI_BURST_LEN    = 16,
    parameter int C_M_AXI_ID_WIDTH     = 1,
    parameter int C_M_AXI_ADDR_WIDTH   = 32,
    parameter int C_M_AXI_DATA_WIDTH   = 64,
    parameter int C_MAX_OUTSTANDING    = 4,
    parameter int C_FRAME_BURSTS_WIDTH = 16
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESETN,
    input  logic                              sof,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     din,
    input  logic                              empty,
    output logic                              rd_en,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     base_addr,
    input  logic [C_FRAME_BURSTS_WIDTH-1:0]   frame_bursts,
    output logic                              frame_pulse,
    output logic                              frame_done,
    output logic                              resp_err,
    output logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                        M_AXI_AWLEN,
    output logic [2:0]                        M_AXI_AWSIZE,
    output logic [1:0]                        M_AXI_AWBURST,
    output logic                              M_AXI_AWLOCK,
    output logic [3:0]                        M_AXI_AWCACHE,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic [3:0]                        M_AXI_AWQOS,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WLAST,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY
);

    localparam int BURST_BYTES = burst_bytes(C_M_AXI_BURST_LEN, C_M_AXI_DATA_WIDTH);
    localparam int OUT_W       = clog2(C_MAX_OUTSTANDING + 1);
    localparam int FBW         = C_FRAME_BURSTS_WIDTH;
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(C_MAX_OUTSTANDING);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STEP = C_M_AXI_ADDR_WIDTH'(BURST_BYTES);

    if (BURST_BYTES > 4096) begin : g_burst_too_big
        $error("fifo2mm_mo: burst length times bus width exceeds 4KB");
    end

    state_e                          state_q, state_d;
    logic                            awvalid_q, awvalid_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [FBW-1:0]                  fbursts_q, fbursts_d;
    logic [FBW-1:0]                  aw_cnt_q, aw_cnt_d;
    logic [FBW-1:0]                  w_cnt_q, w_cnt_d;
    logic [FBW-1:0]                  b_cnt_q, b_cnt_d;
    logic [OUT_W-1:0]                out_q, out_d;
    logic                            frame_done_q, frame_done_d;
    logic frame_active, dvalid, hold_sof, drop, frame_start, aw_hs, b_hs, wnext, w_burst_end;
    logic unused_sink;

    assign frame_active = (state_q == ST_FRAME);
    assign drop         = ~frame_active & dvalid & ~hold_sof;
    assign frame_start  = ~frame_active & dvalid & hold_sof;
    assign aw_hs        = awvalid_q & M_AXI_AWREADY;
    assign b_hs         = frame_active & M_AXI_BVALID;
    assign w_burst_end  = wnext & M_AXI_WLAST;

    fifo2mm_wbeat #(
        .DATA_W    (C_M_AXI_DATA_WIDTH),
        .BURST_LEN (C_M_AXI_BURST_LEN),
        .PEND_W    (OUT_W)
    ) u_wbeat (
        .clk            (M_AXI_ACLK),
        .srst_n_i       (M_AXI_ARESETN),
        .empty_i        (empty),
        .din_i          (din),
        .sof_i          (sof),
        .frame_active_i (frame_active),
        .drop_i         (drop),
        .frame_start_i  (frame_start),
        .aw_hs_i        (aw_hs),
        .wready_i       (M_AXI_WREADY),
        .rd_en_o        (rd_en),
        .dvalid_o       (dvalid),
        .sof_o          (hold_sof),
        .wdata_o        (M_AXI_WDATA),
        .wvalid_o       (M_AXI_WVALID),
        .wlast_o        (M_AXI_WLAST),
        .wnext_o        (wnext)
    );

    always_comb begin
        state_d      = state_q;
        awaddr_d     = awaddr_q;
        fbursts_d    = fbursts_q;
        aw_cnt_d     = aw_cnt_q;
        w_cnt_d      = w_cnt_q;
        b_cnt_d      = b_cnt_q;
        out_d        = out_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d   = ST_FRAME;
                    awaddr_d  = base_addr;
                    fbursts_d = (frame_bursts == '0) ? FBW'(1) : frame_bursts;
                    aw_cnt_d  = '0;
                    w_cnt_d   = '0;
                    b_cnt_d   = '0;
                end
            end
            ST_FRAME: begin
                if (aw_hs) begin
                    aw_cnt_d = aw_cnt_q + 1'b1;
                    awaddr_d = awaddr_q + ADDR_STEP;
                end
                if (w_burst_end) begin
                    w_cnt_d = w_cnt_q + 1'b1;
                end
                if (b_hs) begin
                    b_cnt_d = b_cnt_q + 1'b1;
                end
                if (aw_hs && !b_hs) begin
                    out_d = out_q + 1'b1;
                end else if (!aw_hs && b_hs) begin
                    out_d = out_q - 1'b1;
                end
                if (b_hs && (b_cnt_d == fbursts_q)) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Decided from next-state counts so a new AW can follow a handshake back to back.
        if (awvalid_q && !M_AXI_AWREADY) begin
            awvalid_d = 1'b1;
        end else begin
            awvalid_d = (state_d == ST_FRAME) && (aw_cnt_d < fbursts_d) && (out_d < MAX_OUT);
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q      <= ST_IDLE;
            awvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            fbursts_q    <= '0;
            aw_cnt_q     <= '0;
            w_cnt_q      <= '0;
            b_cnt_q      <= '0;
            out_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            awvalid_q    <= awvalid_d;
            awaddr_q     <= awaddr_d;
            fbursts_q    <= fbursts_d;
            aw_cnt_q     <= aw_cnt_d;
            w_cnt_q      <= w_cnt_d;
            b_cnt_q      <= b_cnt_d;
            out_q        <= out_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef S2MM_RESP_ERR_EN
    logic        resp_err_q, resp_err_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        resp_err_d = resp_err_q;
        err_cnt_d  = err_cnt_q;
        if (frame_start) begin
            resp_err_d = 1'b0;
        end else if (b_hs && M_AXI_BRESP[1]) begin
            resp_err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            resp_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            resp_err_q <= resp_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign unused_sink   = ^{M_AXI_BID, M_AXI_BRESP};
    assign frame_pulse   = frame_start;
    assign frame_done    = frame_done_q;
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'(clog2(C_M_AXI_DATA_WIDTH / 8));
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = AXI_AWCACHE_VAL;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b0000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_BREADY  = 1'b1;

endmodule

// File: tb/tb_fifo2mm_mo.sv
// tb_fifo2mm_mo: randomized bench for fifo2mm_mo; a FIFO/AXI-slave model predicts the
// frame's address list, write-data order, burst boundaries and frame/error flags.
module tb_fifo2mm_mo;

    localparam int BL = 16, DW = 64, AW = 32, IDW = 1, MAXO = 2, FBW = 16;
    localparam int BBYTES = BL * DW / 8;
`ifdef S2MM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic sof = 1'b0, empty = 1'b1, rd_en;
    logic [DW-1:0] din = '0;
    logic [AW-1:0] base_addr = '0;
    logic [FBW-1:0] frame_bursts = '0;
    logic frame_pulse, frame_done, resp_err;
    logic [IDW-1:0] awid, bid = '0;
    logic [AW-1:0] awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize, awprot;
    logic [1:0] awburst, bresp = 2'b00;
    logic [3:0] awcache, awqos;
    logic awlock, awvalid, awready = 1'b0;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic wlast, wvalid, wready = 1'b0, bvalid = 1'b0, bready;

    fifo2mm_mo #(
        .C_M_AXI_BURST_LEN(BL), .C_M_AXI_ID_WIDTH(IDW), .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW), .C_MAX_OUTSTANDING(MAXO), .C_FRAME_BURSTS_WIDTH(FBW)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n), .sof(sof), .din(din), .empty(empty),
        .rd_en(rd_en), .base_addr(base_addr), .frame_bursts(frame_bursts),
        .frame_pulse(frame_pulse), .frame_done(frame_done), .resp_err(resp_err),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
        .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    typedef struct packed { logic sof; logic [DW-1:0] data; } word_t;

    int n_checks = 0, n_fail = 0;
    word_t fifo_q[$];
    logic [DW-1:0] exp_w[$];
    logic [AW-1:0] exp_aw[$];
    logic [AW-1:0] cur_base;
    int cur_fb, frames_exp, frames_done, pulses, pops, pulse_pops;
    int aw_total, w_bursts, b_total, beat_idx, b_in_frame, outstanding, err_burst;
    int p_aw, p_w, p_gap, p_b;
    bit b_en, exp_done, exp_err, pop_pend, prev_wstall, prev_awstall;
    logic [DW-1:0] prev_wdata;
    logic [AW-1:0] prev_awaddr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic reset_model();
        fifo_q.delete(); exp_w.delete(); exp_aw.delete();
        frames_exp = 0; frames_done = 0; pulses = 0; pops = 0; pulse_pops = -1;
        aw_total = 0; w_bursts = 0; b_total = 0; beat_idx = 0; b_in_frame = 0; outstanding = 0;
        exp_done = 0; exp_err = 0; pop_pend = 0; prev_wstall = 0; prev_awstall = 0;
    endtask

    task automatic set_rates(input int aw_p, input int w_p, input int gap_p, input int b_p);
        p_aw = aw_p; p_w = w_p; p_gap = gap_p; p_b = b_p;
    endtask

    task automatic set_frame(input logic [AW-1:0] base, input int fb);
        base_addr = base;
        frame_bursts = FBW'(fb);
        cur_base = base;
        cur_fb = (fb == 0) ? 1 : fb;
    endtask

    task automatic push_frame(input int junk, input bit mid_sof);
        logic [DW-1:0] d;
        logic s;
        for (int i = 0; i < junk; i++) fifo_q.push_back({1'b0, rand_word()});
        for (int k = 0; k < cur_fb; k++) exp_aw.push_back(cur_base + AW'(k * BBYTES));
        for (int i = 0; i < cur_fb * BL; i++) begin
            d = rand_word();
            s = (i == 0) ? 1'b1 : (mid_sof && ($urandom_range(7) == 0));
            fifo_q.push_back({s, d});
            exp_w.push_back(d);
        end
        frames_exp++;
    endtask

    task automatic drive_inputs();
        if (pop_pend) begin
            void'(fifo_q.pop_front());
            pop_pend = 0;
        end
        if (fifo_q.size() > 0 && $urandom_range(99) >= p_gap) begin
            empty = 1'b0; din = fifo_q[0].data; sof = fifo_q[0].sof;
        end else begin
            empty = 1'b1; din = '0; sof = 1'b0;
        end
        awready = ($urandom_range(99) < p_aw);
        wready  = ($urandom_range(99) < p_w);
        bvalid  = b_en && (w_bursts > b_total) && ($urandom_range(99) < p_b);
        bresp   = (bvalid && b_in_frame == err_burst) ? 2'b10 : 2'b00;
    endtask

    task automatic monitor();
        check_val("frame_done", frame_done, exp_done);
        exp_done = 0;
        check_val("resp_err", resp_err, exp_err);
        if (prev_wstall) begin
            check_val("wvalid_hold", wvalid, 1);
            check_val("wdata_hold", wdata, prev_wdata);
        end
        if (prev_awstall) begin
            check_val("awvalid_hold", awvalid, 1);
            check_val("awaddr_hold", awaddr, prev_awaddr);
        end
        if (frame_pulse) begin
            pulses++;
            if (pulse_pops < 0) pulse_pops = pops;
            check_val("idle_awvalid", awvalid, 0);
            check_val("idle_wvalid", wvalid, 0);
        end
        if (wvalid && wready) begin
            check_val("w_after_aw", aw_total > w_bursts, 1);
            check_val("wstrb", wstrb, {(DW/8){1'b1}});
            if (exp_w.size() == 0) check_val("w_extra", 1, 0);
            else check_val("wdata", wdata, exp_w.pop_front());
            check_val("wlast", wlast, beat_idx == BL - 1);
            if (beat_idx == BL - 1) begin
                beat_idx = 0;
                w_bursts++;
            end else begin
                beat_idx++;
            end
        end
        if (awvalid && awready) begin
            check_val("aw_limit", outstanding < MAXO, 1);
            check_val("awlen", awlen, BL - 1);
            if (exp_aw.size() == 0) check_val("aw_extra", 1, 0);
            else check_val("awaddr", awaddr, exp_aw.pop_front());
            aw_total++;
            outstanding++;
        end
        if (bvalid) begin
            b_total++;
            outstanding--;
            b_in_frame++;
            if (b_in_frame == cur_fb) begin
                exp_done = 1;
                b_in_frame = 0;
                frames_done++;
            end
        end
        if (frame_pulse) exp_err = 0;
        else if (ERR_EN && bvalid && bresp[1]) exp_err = 1;
        if (rd_en) begin
            check_val("rd_en_empty", empty, 0);
            pop_pend = 1;
            pops++;
        end
        prev_wstall = wvalid && !wready;
        prev_wdata = wdata;
        prev_awstall = awvalid && !awready;
        prev_awaddr = awaddr;
    endtask

    task automatic step();
        drive_inputs();
        #1;
        if (rst_n) monitor();
        @(negedge clk);
    endtask

    task automatic run_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!(fifo_q.size() == 0 && exp_w.size() == 0 && exp_aw.size() == 0 &&
                 frames_done == frames_exp)) begin
            step();
            n++;
            if (n > budget) begin
                check_val({tag, "_timeout"}, 0, 1);
                break;
            end
        end
        step();
        step();
        check_val({tag, "_pulses"}, pulses, frames_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_model();
        set_rates(100, 100, 0, 100);
        b_en = 1; err_burst = -1; cur_fb = 1;
        @(negedge clk);
        repeat (3) step();
        check_val("rst_rd_en", rd_en, 0);
        check_val("rst_frame_pulse", frame_pulse, 0);
        check_val("rst_frame_done", frame_done, 0);
        check_val("rst_resp_err", resp_err, 0);
        check_val("rst_awvalid", awvalid, 0);
        check_val("rst_wvalid", wvalid, 0);
        check_val("rst_wlast", wlast, 0);
        check_val("rst_awaddr", awaddr, 0);
        check_val("bready", bready, 1);
        check_val("awconst", {awid, awsize, awburst, awlock, awcache, awprot, awqos},
                  {1'b0, 3'd3, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
        rst_n = 1'b1;

        // Frame of 4 bursts, everything ready.
        set_frame(32'h1000_0000, 4);
        push_frame(0, 0);
        run_done("t1", 2000);

        // Outstanding limit with B withheld.
        b_en = 0;
        set_frame(32'h2000_0800, 5);
        push_frame(0, 0);
        repeat (80) step();
        check_val("t2_aw_count", aw_total - 4, 2);
        check_val("t2_awvalid_low", awvalid, 0);
        b_en = 1;
        run_done("t2", 2000);

        // Non-sof words dropped in IDLE before the frame.
        pops = 0; pulse_pops = -1;
        set_frame(32'h3000_0000, 2);
        push_frame(3, 0);
        run_done("t3", 2000);
        check_val("t3_pops_at_pulse", pulse_pops, 4);

        // Random stalls, FIFO gaps and stray mid-frame sof flags.
        set_rates(60, 60, 30, 50);
        set_frame({$urandom_range(32'hFFFF), 10'h000} & ~32'(BBYTES - 1), 3);
        for (int f = 0; f < 3; f++) push_frame($urandom_range(2), 1);
        run_done("t4", 6000);

        // Error response on the second burst, then a clean frame.
        set_rates(100, 100, 0, 100);
        err_burst = 1;
        set_frame(32'h4000_0000, 3);
        push_frame(0, 0);
        run_done("t5a", 2000);
        check_val("t5_err_held", resp_err, ERR_EN);
        err_burst = -1;
        push_frame(1, 0);
        run_done("t5b", 2000);
        check_val("t5_err_cleared", resp_err, 0);

        // Zero frame length runs one burst; addresses wrap at the top of memory.
        set_frame(32'h5000_0000, 0);
        push_frame(0, 0);
        run_done("t7", 2000);
        set_frame(32'hFFFF_FF00, 3);
        push_frame(0, 0);
        run_done("t8", 2000);

        // Reset in the middle of a burst.
        set_frame(32'h6000_0000, 2);
        push_frame(0, 0);
        n = 0;
        while (!(w_bursts == aw_total - 1 && beat_idx == 7) && n < 500) begin
            step();
            n++;
        end
        check_val("t6_reached_beat7", beat_idx, 7);
        rst_n = 1'b0;
        step();
        check_val("t6_awvalid", awvalid, 0);
        check_val("t6_wvalid", wvalid, 0);
        check_val("t6_frame_done", frame_done, 0);
        check_val("t6_rd_en", rd_en, 0);
        reset_model();
        step();
        rst_n = 1'b1;
        set_frame(32'h7000_0000, 2);
        push_frame(1, 0);
        run_done("t6", 2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
